// File: rtl/pc_fetch_stage.sv
//------------------------------------------------------------------------------
// pc_fetch_stage
//
// Instruction fetch stage sitting directly downstream of the next-PC select
// mux. It owns the program counter, exports pc+4 as the mux's sequential
// input, issues one instruction-memory read at a time over a valid/ready
// request channel with a separate response-valid strobe, and fills the IF/ID
// pipeline register.
//
// Fetch sequencing (one request outstanding at most):
//   S_REQ  : present pc on the request channel until it is accepted.
//   S_WAIT : request accepted, waiting for the response word.
//   S_HOLD : response arrived while the hazard unit was stalling; the word is
//            parked in a hold buffer until the stall drops.
//
// Ports:
//   clk             in   1   rising-edge clock
//   rst             in   1   synchronous, active-high reset
//   next_pc         in   32  next-PC mux output (pc+4 or branch/jump target)
//   redirect        in   1   taken branch or jump; next_pc holds the target
//   stall           in   1   hazard stall; freezes IF/ID
//   pc              out  32  current fetch PC
//   pc_plus4        out  32  pc + 4 (wraps modulo 2^32)
//   imem_req_valid  out  1   fetch request valid
//   imem_req_addr   out  32  fetch address (always equals pc)
//   imem_req_ready  in   1   memory accepts the request
//   imem_resp_valid in   1   instruction word valid
//   imem_resp_data  in   32  instruction word
//   if_valid        out  1   IF/ID holds a real instruction
//   if_pc           out  32  PC of the IF/ID instruction
//   if_instr        out  32  IF/ID instruction word
//   if_pc_plus4     out  32  PC+4 of the IF/ID instruction
//------------------------------------------------------------------------------
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Fetch sequencer state.
  logic [1:0]  r_state;
  logic [31:0] r_pc;
  // Set when the in-flight request was overtaken by a redirect: its response
  // must be thrown away when it eventually arrives.
  logic        r_discard;

  // Hold buffer for a response that arrived during a stall.
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_instr;

  // IF/ID pipeline register.
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc_plus4;

  // Next-state and datapath selects.
  logic [1:0]  w_state_next;
  logic [31:0] w_pc_next;
  logic        w_discard_next;
  logic        w_hold_load;
  logic        w_deliver;
  logic [31:0] w_del_pc;
  logic [31:0] w_del_instr;
  logic [31:0] w_del_pc_plus4;

  //----------------------------------------------------------------------------
  // Request channel. The request is withdrawn in a redirect cycle so that the
  // memory never sees the stale (about to be replaced) PC. Because pc only
  // changes on a redirect or after a response, the address is stable for as
  // long as valid is high.
  //----------------------------------------------------------------------------
  assign imem_req_valid = (r_state == S_REQ) && !redirect && !rst;
  assign imem_req_addr  = r_pc;
  assign pc             = r_pc;
  assign pc_plus4       = r_pc + 32'd4;

  //----------------------------------------------------------------------------
  // Sequencer next-state logic.
  //----------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_discard_next = r_discard;
    w_hold_load    = 1'b0;
    w_deliver      = 1'b0;
    w_del_pc       = r_pc;
    w_del_instr    = imem_resp_data;

    case (r_state)
      S_REQ: begin
        if (redirect) begin
          w_pc_next = next_pc;
        end else if (imem_req_ready) begin
          w_state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect && imem_resp_valid) begin
          // The outstanding response is consumed right here, so nothing is
          // left to discard regardless of any earlier redirect.
          w_pc_next      = next_pc;
          w_discard_next = 1'b0;
          w_state_next   = S_REQ;
        end else if (redirect) begin
          w_pc_next      = next_pc;
          w_discard_next = 1'b1;
        end else if (imem_resp_valid && r_discard) begin
          // pc already holds the redirect target; just reissue from it.
          w_discard_next = 1'b0;
          w_state_next   = S_REQ;
        end else if (imem_resp_valid && !stall) begin
          w_deliver    = 1'b1;
          w_pc_next    = next_pc;
          w_state_next = S_REQ;
        end else if (imem_resp_valid) begin
          w_hold_load  = 1'b1;
          w_state_next = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          w_pc_next    = next_pc;
          w_state_next = S_REQ;
        end else if (!stall) begin
          w_deliver    = 1'b1;
          w_del_pc     = r_hold_pc;
          w_del_instr  = r_hold_instr;
          w_pc_next    = next_pc;
          w_state_next = S_REQ;
        end
      end

      default: begin
        w_state_next = S_REQ;
      end
    endcase
  end

  assign w_del_pc_plus4 = w_del_pc + 32'd4;

  //----------------------------------------------------------------------------
  // Sequencer and hold-buffer registers.
  //----------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_discard    <= 1'b0;
      r_hold_pc    <= 32'h0;
      r_hold_instr <= 32'h0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_discard <= w_discard_next;
      if (w_hold_load) begin
        r_hold_pc    <= r_pc;
        r_hold_instr <= imem_resp_data;
      end
    end
  end

  //----------------------------------------------------------------------------
  // IF/ID register. A redirect flushes (wins over stall); a stall freezes all
  // fields; otherwise the register takes a delivered instruction or becomes a
  // bubble while keeping its last data fields.
  //----------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid    <= 1'b0;
      r_if_pc       <= 32'h0;
      r_if_instr    <= 32'h0;
      r_if_pc_plus4 <= 32'h0;
    end else if (redirect) begin
      r_if_valid <= 1'b0;
    end else if (!stall) begin
      r_if_valid <= w_deliver;
      if (w_deliver) begin
        r_if_pc       <= w_del_pc;
        r_if_instr    <= w_del_instr;
        r_if_pc_plus4 <= w_del_pc_plus4;
      end
    end
  end

  assign if_valid    = r_if_valid;
  assign if_pc       = r_if_pc;
  assign if_instr    = r_if_instr;
  assign if_pc_plus4 = r_if_pc_plus4;

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;

  int checks   = 0;
  int failures = 0;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .next_pc         (next_pc),
    .redirect        (redirect),
    .stall           (stall),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_pc_plus4     (if_pc_plus4)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: which fetch is in flight, whether its
  // response is owed to the bin, whether a word is parked, and what the
  // decode stage currently sees.
  logic [31:0] m_pc;
  bit          m_inflight;
  bit          m_stale;
  bit          m_parked;
  logic [31:0] m_park_pc, m_park_ins;
  bit          m_ifv;
  logic [31:0] m_ifpc, m_ifins, m_ifpc4;
  bit          last_fire;

  // Memory model for the random phase.
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_inflight = 0; m_stale = 0; m_parked = 0;
    m_park_pc = 0; m_park_ins = 0;
    m_ifv = 0; m_ifpc = 0; m_ifins = 0; m_ifpc4 = 0;
  endtask

  // One clock cycle: drive inputs, check the request side, clock, advance the
  // reference, check the registered side.
  task automatic cycle(input logic rd, input logic st, input logic [31:0] tgt,
                       input logic rdy, input logic rv, input logic [31:0] rdata);
    logic        exp_req;
    logic [31:0] npc;
    bit          resp, got;
    logic [31:0] g_pc, g_ins;
    @(negedge clk);
    npc             = rd ? tgt : m_pc + 32'd4;
    redirect        = rd;
    stall           = st;
    next_pc         = npc;
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rdata;
    exp_req = !rst && !m_inflight && !m_parked && !rd;
    #1;
    chk1("req_valid", imem_req_valid, exp_req);
    if (!rst) begin
      chk32("pc", pc, m_pc);
      chk32("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk32("req_addr", imem_req_addr, m_pc);
    end
    last_fire = exp_req && rdy;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      resp = rv && m_inflight;
      got  = 0;
      g_pc = 0; g_ins = 0;
      if (rd) begin
        m_pc = npc;
        if (m_inflight) begin
          if (resp) begin m_inflight = 0; m_stale = 0; end
          else m_stale = 1;
        end
        m_parked = 0;
        m_ifv = 0;
      end else begin
        if (last_fire) begin
          m_inflight = 1;
        end else if (resp) begin
          m_inflight = 0;
          if (m_stale) m_stale = 0;
          else if (!st) begin got = 1; g_pc = m_pc; g_ins = rdata; m_pc = npc; end
          else begin m_parked = 1; m_park_pc = m_pc; m_park_ins = rdata; end
        end else if (m_parked && !st) begin
          got = 1; g_pc = m_park_pc; g_ins = m_park_ins; m_parked = 0; m_pc = npc;
        end
        if (!st) begin
          m_ifv = got;
          if (got) begin
            m_ifpc = g_pc; m_ifins = g_ins; m_ifpc4 = g_pc + 32'd4;
            $display("fetch pc=%h instr=%h", g_pc, g_ins);
          end
        end
      end
    end
    #1;
    chk32("pc_after", pc, m_pc);
    chk1("if_valid", if_valid, m_ifv);
    chk32("if_pc", if_pc, m_ifpc);
    chk32("if_instr", if_instr, m_ifins);
    chk32("if_pc_plus4", if_pc_plus4, m_ifpc4);
  endtask

  // Request accepted immediately, response the next cycle.
  task automatic fetch(input logic [31:0] data);
    cycle(0, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 0, 32'h0, 1, 1, data);
  endtask

  initial begin
    logic [31:0] t, rdata;
    logic        rd, st, rdy, rv;
    logic [31:0] a_before;

    clk = 0; rst = 1;
    next_pc = 0; redirect = 0; stall = 0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
    model_reset();
    last_fire = 0; mem_pend = 0; mem_cnt = 0; mem_addr = 0;

    // Reset.
    cycle(0, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 0, 32'h0, 1, 0, 32'h0);
    chk32("reset_pc", pc, 32'h0);
    chk1("reset_if_valid", if_valid, 1'b0);
    chk32("reset_if_instr", if_instr, 32'h0);
    rst = 0;

    // Sequential fetches at 0, 4, 8.
    fetch(32'h1111_0000);
    chk1("seq0_valid", if_valid, 1'b1);
    chk32("seq0_pc", if_pc, 32'h0);
    fetch(32'h1111_0004);
    chk32("seq1_pc", if_pc, 32'h4);
    chk32("seq1_instr", if_instr, 32'h1111_0004);
    fetch(32'h1111_0008);
    chk32("seq2_pc", if_pc, 32'h8);
    chk32("seq2_pc4", if_pc_plus4, 32'hC);
    fetch(32'h1111_000C);

    // Stall during the wait: response parked, delivered after the stall.
    cycle(0, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 1, 32'h0, 1, 1, 32'h2002_0001);
    chk32("stall_hold_pc", if_pc, 32'hC);
    chk32("stall_pc_frozen", pc, 32'h10);
    cycle(0, 1, 32'h0, 1, 0, 32'h0);
    cycle(0, 1, 32'h0, 1, 0, 32'h0);
    chk32("stall_hold_instr", if_instr, 32'h1111_000C);
    cycle(0, 0, 32'h0, 1, 0, 32'h0);
    chk32("stall_rel_instr", if_instr, 32'h2002_0001);
    chk32("stall_rel_pc", if_pc, 32'h10);
    chk32("stall_pc_once", pc, 32'h14);

    // Redirect while waiting, response dropped two cycles later.
    fetch(32'h1111_0014);
    fetch(32'h1111_0018);
    fetch(32'h1111_001C);
    chk32("pre_redirect_pc", pc, 32'h20);
    cycle(0, 0, 32'h0, 1, 0, 32'h0);
    cycle(1, 0, 32'h100, 1, 0, 32'h0);
    chk32("redir_pc", pc, 32'h100);
    cycle(0, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 0, 32'h0, 1, 1, 32'hDEAD_BEEF);
    chk1("redir_drop_valid", if_valid, 1'b0);
    chk1("redir_req_valid", imem_req_valid, 1'b1);
    chk32("redir_req_addr", imem_req_addr, 32'h100);

    // Redirect coinciding with the response.
    cycle(0, 0, 32'h0, 1, 0, 32'h0);
    cycle(1, 0, 32'h200, 1, 1, 32'hBAD0_0001);
    chk32("redir_same_pc", pc, 32'h200);
    chk1("redir_same_valid", if_valid, 1'b0);
    fetch(32'h3300_0200);
    chk1("redir_same_next_valid", if_valid, 1'b1);
    chk32("redir_same_next_pc", if_pc, 32'h200);
    chk32("redir_same_next_instr", if_instr, 32'h3300_0200);

    // PC wrap.
    cycle(1, 0, 32'hFFFF_FFFC, 1, 0, 32'h0);
    chk32("wrap_pc", pc, 32'hFFFF_FFFC);
    chk32("wrap_pc_plus4", pc_plus4, 32'h0);
    fetch(32'h4400_0044);
    chk32("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk32("wrap_if_pc4", if_pc_plus4, 32'h0);
    chk32("wrap_req_addr", imem_req_addr, 32'h0);

    // Reset mid-transaction, stale response afterwards.
    cycle(0, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 0, 32'h0, 1, 0, 32'h0);
    rst = 1;
    cycle(0, 0, 32'h0, 0, 0, 32'h0);
    rst = 0;
    cycle(0, 0, 32'h0, 0, 1, 32'h5555_5555);
    chk1("rst_stale_valid", if_valid, 1'b0);
    chk32("rst_stale_instr", if_instr, 32'h0);
    chk32("rst_pc", pc, 32'h0);
    chk1("rst_req_valid", imem_req_valid, 1'b1);
    chk32("rst_req_addr", imem_req_addr, 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      rv = 0;
      rdata = $urandom;
      if (mem_pend && mem_cnt == 0) begin
        rv = 1;
        rdata = mem_word(mem_addr);
      end else if (!mem_pend && $urandom_range(0, 9) == 0) begin
        rv = 1;
      end
      rd  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      t = $urandom;
      t[1:0] = 2'b00;
      a_before = m_pc;
      cycle(rd, st, t, rdy, rv, rdata);
      if (mem_pend) begin
        if (rv) mem_pend = 0;
        else mem_cnt--;
      end
      if (last_fire) begin
        mem_pend = 1;
        mem_addr = a_before;
        mem_cnt  = $urandom_range(0, 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Fetch stage directly downstream of the next-PC select mux. Holds the program counter and exports PC+4 as the mux's sequential input. Loads the mux output on each advance.
- Issues instruction-memory reads over a valid/ready request plus response-valid handshake. Fills the IF/ID pipeline register.
- Honours a hazard stall and a redirect/flush for taken branches and jumps.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- next_pc  input  32  output of the next-PC select mux.
- redirect  input  1  branch taken or jump; next_pc holds the target.
- stall  input  1  hazard-unit stall; freezes IF/ID.
- pc  output  32  current fetch PC.
- pc_plus4  output  32  pc + 4, to the mux sequential input.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  fetch address; always equals pc.
- imem_req_ready  input  1  memory accepts the request.
- imem_resp_valid  input  1  instruction data valid.
- imem_resp_data  input  32  instruction word.
- if_valid  output  1  IF/ID register holds a real instruction.
- if_pc  output  32  PC of the IF/ID instruction.
- if_instr  output  32  IF/ID instruction word.
- if_pc_plus4  output  32  PC+4 of the IF/ID instruction.

Behaviour:
- Reset (on any clk edge with rst=1, including mid-transaction):
  - pc=RESET_PC, state=S_REQ, discard=0, hold buffer=0.
  - if_valid=0; if_pc, if_instr, if_pc_plus4 = 0.
  - imem_req_valid=0 while rst=1.
  - A response arriving in the cycle after reset is ignored because state is S_REQ.
- pc_plus4 is combinational, 32-bit, and wraps modulo 2^32 (FFFF_FFFC -> 0000_0000).
- imem_req_valid = (state==S_REQ) && !redirect && !rst. The address is stable while valid is high.
- S_REQ:
  - Handshake (valid && ready) -> S_WAIT.
  - Otherwise stay.
  - Redirect -> pc<=next_pc, stay in S_REQ; no stale request is issued.
- S_WAIT, arbitrated in this order:
  - redirect && resp_valid -> drop the response, pc<=next_pc, -> S_REQ, discard stays 0.
  - redirect -> pc<=next_pc, discard<=1, stay in S_WAIT.
  - resp_valid && discard -> drop the response, discard<=0, -> S_REQ.
  - resp_valid && !stall -> load IF/ID {pc, resp_data, pc+4}, if_valid<=1, pc<=next_pc, -> S_REQ.
  - resp_valid && stall -> capture {pc, data} into the hold buffer, -> S_HOLD.
- S_HOLD:
  - redirect -> drop the buffer, pc<=next_pc, -> S_REQ.
  - stall=0 -> load IF/ID from the buffer, if_valid<=1, pc<=next_pc, -> S_REQ.
  - Otherwise stay.
- IF/ID register:
  - Redirect forces if_valid<=0 (flush); this has priority over stall.
  - Else stall=1 holds all IF/ID outputs.
  - Else, in a cycle with no delivery, if_valid<=0 (bubble) and the data fields hold their last value.
- The next_pc sampled at advance is the mux output in that cycle (PC+4 when no branch or jump).
- Latency: request accepted in cycle N, earliest response in N+1, if_valid high from the N+1 edge. Peak throughput is 1 instruction per 2 cycles.
- A redirect while discard=1 updates pc and keeps discard=1. Exactly one response is dropped per outstanding request.
- Only one request is outstanding at a time. resp_valid outside S_WAIT is ignored.

Test Plan:
- Reset with RESET_PC=0, then release rst; memory ready=1, response 1 cycle later, next_pc=pc_plus4 -> requests at 0x0, 0x4, 0x8 on every other cycle; if_pc=0,4,8 with matching if_instr; if_valid pulses high.
- Stall raised during S_WAIT for 3 cycles, response 0x2002_0001 at 0x10 -> IF/ID holds its prior values; after stall drops, if_instr=0x2002_0001, if_pc=0x10; pc advances exactly once.
- Redirect to 0x100 during S_WAIT at pc=0x20; response arrives 2 cycles later -> response dropped, if_valid=0; next request addr=0x100.
- Redirect to 0x200 in the same cycle as resp_valid -> response dropped, no discard pending; next request addr=0x200; the following response is delivered normally.
- pc=0xFFFF_FFFC -> pc_plus4=0x0000_0000; after delivery, next request addr=0x0.
- rst asserted in S_WAIT, then a stale resp_valid in the following cycle -> response ignored, if_valid=0, first request addr=RESET_PC.
